// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_AW        = 32;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 4;

  // Wide enough for the largest legal MAX_BURST (15).
  localparam int BEAT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters (CPU m0, DMA m1), the arbiter and the memory.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_burst_cnt.sv
// Beat counter for the current owner: clears on owner change, saturates at MAX_BURST.
module arb_burst_cnt import mem_arb_pkg::*; #(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [BEAT_CNT_W-1:0] MAX_C = BEAT_CNT_W'(MAX_BURST);

  logic [BEAT_CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted in the cycle whose beat brings the count to MAX_BURST, so the
  // hand-over lands on the very next edge.
  assign at_max = (cnt == MAX_C) || (inc && (cnt == (MAX_C - 1'b1)));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a shared 1-cycle-latency data memory.
// Define MEM_ARB_RR_EN for round-robin ties and symmetric burst preemption.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          gnt0;
  logic          gnt1;
  logic          burst_max;
  logic          m1_wins_tie;
  logic [1:0]    rd_vld_p1;
  logic          mem_en_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;

`ifdef MEM_ARB_RR_EN
  localparam bit PREEMPT_OWN0 = 1'b1;

  logic last_owner;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state_nxt == OWN0) begin
      last_owner <= 1'b0;
    end else if (state_nxt == OWN1) begin
      last_owner <= 1'b1;
    end
  end

  assign m1_wins_tie = ~last_owner;
`else
  // CPU has fixed priority: DMA only takes over once the CPU lets go.
  localparam bit PREEMPT_OWN0 = 1'b0;

  assign m1_wins_tie = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_nxt = m1_wins_tie ? OWN1 : OWN0;
        end else if (bus.m0_req) begin
          state_nxt = OWN0;
        end else if (bus.m1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.m0_req && !bus.m1_req) begin
          state_nxt = IDLE;
        end else if (bus.m1_req && (!bus.m0_req || (PREEMPT_OWN0 && burst_max))) begin
          state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!bus.m0_req && !bus.m1_req) begin
          state_nxt = IDLE;
        end else if (bus.m0_req && (!bus.m1_req || burst_max)) begin
          state_nxt = OWN0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      OWN0: begin
        gnt0        = bus.m0_req;
        mem_en_c    = bus.m0_req;
        mem_we_c    = bus.m0_req & bus.m0_we;
        mem_addr_c  = bus.m0_addr;
        mem_wdata_c = bus.m0_wdata;
      end
      OWN1: begin
        gnt1        = bus.m1_req;
        mem_en_c    = bus.m1_req;
        mem_we_c    = bus.m1_req & bus.m1_we;
        mem_addr_c  = bus.m1_addr;
        mem_wdata_c = bus.m1_wdata;
      end
      default: ;
    endcase
  end

  arb_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    (state_nxt != state),
    .inc    (gnt0 | gnt1),
    .at_max (burst_max)
  );

  // p1: read-beat flags line up with the memory's registered read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld_p1 <= 2'b00;
    end else begin
      rd_vld_p1 <= {gnt1 & ~bus.m1_we, gnt0 & ~bus.m0_we};
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.m0_rvalid = rd_vld_p1[0];
  assign bus.m1_rvalid = rd_vld_p1[1];
  assign bus.m0_rdata  = rd_vld_p1[0] ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = rd_vld_p1[1] ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;

  logic clock;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(
    .AW        (32),
    .DW        (32),
    .MAX_BURST (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:255];

  always @(posedge clock) begin
    if (reset) begin
      mem[8'h10] <= 32'hDEADBEEF;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req   = req;
    bus.m0_we    = we;
    bus.m0_addr  = addr;
    bus.m0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m1_req   = req;
    bus.m1_we    = we;
    bus.m1_addr  = addr;
    bus.m1_wdata = wdata;
  endtask

  initial begin
    logic exp1;
    logic prev_g0;
    logic prev_g1;

    reset = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_m0_gnt", bus.m0_gnt, 0);
    check("rst_m1_gnt", bus.m1_gnt, 0);
    check("rst_m0_rvalid", bus.m0_rvalid, 0);
    check("rst_m1_rvalid", bus.m1_rvalid, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_m0_rdata", bus.m0_rdata, 0);

    // m0 alone reads 0x10
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("rd_idle_no_gnt", bus.m0_gnt, 0);
    tick();
    check("rd_m0_gnt", bus.m0_gnt, 1);
    check("rd_m1_gnt", bus.m1_gnt, 0);
    check("rd_mem_en", bus.mem_en, 1);
    check("rd_mem_we", bus.mem_we, 0);
    check("rd_mem_addr", bus.mem_addr, 32'h10);
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rd_m0_rvalid", bus.m0_rvalid, 1);
    check("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("rd_m1_rvalid", bus.m1_rvalid, 0);
    tick();
    check("rd_rvalid_once", bus.m0_rvalid, 0);

    // m1 writes 0x55 to 0x20, then m0 reads it back
    drive1(1'b1, 1'b1, 32'h20, 32'h55);
    #1;
    check("wr_idle_no_gnt", bus.m1_gnt, 0);
    tick();
    check("wr_m1_gnt", bus.m1_gnt, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 32'h20);
    check("wr_mem_wdata", bus.mem_wdata, 32'h55);
    tick();
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    check("wr_we_one_cycle", bus.mem_we, 0);
    check("wr_nonowner_gnt", bus.m0_gnt, 0);
    check("wr_no_rvalid", bus.m1_rvalid, 0);
    tick();
    check("rb_m0_gnt", bus.m0_gnt, 1);
    check("rb_mem_addr", bus.mem_addr, 32'h20);
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rb_m0_rvalid", bus.m0_rvalid, 1);
    check("rb_m0_rdata", bus.m0_rdata, 32'h55);
    tick();

    // both masters held from IDLE right after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive0(1'b1, 1'b0, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    check("both_idle_m0_gnt", bus.m0_gnt, 0);
    check("both_idle_m1_gnt", bus.m1_gnt, 0);
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
`ifdef MEM_ARB_RR_EN
      exp1 = (((i - 1) / 4) % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      check($sformatf("both_m0_gnt_%0d", i), bus.m0_gnt, !exp1);
      check($sformatf("both_m1_gnt_%0d", i), bus.m1_gnt, exp1);
      check($sformatf("both_m0_rvalid_%0d", i), bus.m0_rvalid, prev_g0);
      check($sformatf("both_m1_rvalid_%0d", i), bus.m1_rvalid, prev_g1);
      prev_g0 = !exp1;
      prev_g1 = exp1;
    end
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("drop_m0_gnt", bus.m0_gnt, 0);
    check("drop_m1_gnt", bus.m1_gnt, 0);
    check("drop_m0_rvalid", bus.m0_rvalid, 1);
    tick();
    check("after_drop_m1_gnt", bus.m1_gnt, 1);

    // reset lands on an m1 read beat
    reset = 1'b1;
    tick();
    check("rst_beat_m1_rvalid", bus.m1_rvalid, 0);
    check("rst_beat_m1_gnt", bus.m1_gnt, 0);
    check("rst_beat_mem_en", bus.mem_en, 0);
    reset = 1'b0;
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rst_beat_m1_rvalid2", bus.m1_rvalid, 0);

    // m0 withdraws a request while m1 owns the memory
    drive1(1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("cancel_m1_gnt", bus.m1_gnt, 1);
    check("cancel_m0_gnt", bus.m0_gnt, 0);
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("cancel_m0_gnt2", bus.m0_gnt, 0);
    check("cancel_mem_addr", bus.mem_addr, 32'h8);
    check("cancel_m0_rvalid", bus.m0_rvalid, 0);
    tick();
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("cancel_m0_rvalid2", bus.m0_rvalid, 0);
    check("cancel_m1_rvalid", bus.m1_rvalid, 1);
    tick();
    check("cancel_m0_rvalid3", bus.m0_rvalid, 0);
    check("cancel_mem_en", bus.mem_en, 0);

    // m1 burst is cut after MAX_BURST beats when m0 waits
    drive1(1'b1, 1'b1, 32'h30, 32'h77);
    tick();
    drive0(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    check("pre_m1_gnt_1", bus.m1_gnt, 1);
    check("pre_m0_gnt_1", bus.m0_gnt, 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("pre_m1_gnt_%0d", i), bus.m1_gnt, i <= 4);
      check($sformatf("pre_m0_gnt_%0d", i), bus.m0_gnt, i == 5);
    end
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("pre_m0_rvalid", bus.m0_rvalid, 1);
    check("pre_m0_rdata", bus.m0_rdata, 32'h55);
    check("pre_idle_m0_gnt", bus.m0_gnt, 0);
    check("pre_idle_m1_gnt", bus.m1_gnt, 0);
    tick();
    check("end_mem_en", bus.mem_en, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
